lvs_stream_driver: RTL and testbench
====================================

Name: lvs_stream_driver

Overview:
Stimulus-side source for the 256-bit LVS data interface. Holds a programmable table of LVS entries and replays it as a valid/ready stream, with optional inter-beat gaps. The block sits in the testbench/bring-up path and drives the same valid + lvs bus that the golden-data checker captures. Software or the bench loads the table through a simple write port, then issues a start pulse.

Parameters:
DEPTH, 64, number of table entries (power of two, 2..1024)
LVS_W, 256, entry width in bits (8 x 32-bit words)
GAP_W, 8, width of the inter-beat gap count

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
wr_en  in  1  table write strobe
wr_addr  in  $clog2(DEPTH)  table write address
wr_data  in  LVS_W  table write data
start  in  1  single-cycle start pulse
abort  in  1  single-cycle abort pulse
num_entries  in  $clog2(DEPTH)+1  beats to send, sampled at start
gap_cycles  in  GAP_W  idle cycles after each accepted beat, sampled at start
lvs_ready  in  1  sink ready; tie to 1 for checker-style sinks
lvs_valid  out  1  beat valid, registered
lvs_out  out  LVS_W  beat data, registered
busy  out  1  high from the cycle after an accepted start until done/abort
done  out  1  one-cycle pulse after the last beat is accepted
sent_cnt  out  $clog2(DEPTH)+1  beats accepted in the current or last run

Behaviour:
- Reset: lvs_valid=0, lvs_out=0, busy=0, done=0, sent_cnt=0, FSM=IDLE. Table contents are not reset.
- FSM states: IDLE, SEND, GAP, FIN.
- IDLE:
  - start=1 with num_entries>0: latch num_entries and gap_cycles, set idx=0, clear sent_cnt, go to SEND.
  - Next cycle (T+1): lvs_valid=1, lvs_out=table[0], busy=1.
  - start=1 with num_entries==0: go to FIN directly. No beat is sent; done pulses at T+1.
- SEND:
  - lvs_valid=1.
  - While lvs_ready=0, lvs_valid and lvs_out hold stable.
  - Beat is accepted when lvs_valid & lvs_ready: sent_cnt+1, idx+1.
  - If the accepted beat was the last (sent_cnt+1 == latched count): go to FIN and drop lvs_valid.
  - Otherwise, if gap>0: go to GAP with lvs_valid=0 and load the gap counter.
  - Otherwise: stay in SEND with lvs_out=table[idx+1] on the next cycle (back-to-back, 1 beat/cycle).
- GAP: lvs_valid=0. Decrement the counter. When it would reach 0, go to SEND; the next beat is presented exactly gap_cycles cycles after the prior acceptance.
- FIN: done=1 for exactly one cycle, busy=0, return to IDLE. sent_cnt holds until the next start.
- Table read is combinational from idx; lvs_out is registered. Latency from start to first valid is 1 cycle.
- start while busy: ignored.
- abort: in any non-IDLE state → next cycle IDLE, lvs_valid=0, busy=0, no done. sent_cnt keeps the accepted count. abort has priority over acceptance in the same cycle; that beat is not counted.
- abort and start in the same IDLE cycle: abort wins, no run starts.
- wr_en while busy: the write is ignored, which protects the table. wr_en in IDLE: write occurs at the clock edge. A write in the same cycle as start is applied, and the started run sees the new value.
- num_entries > DEPTH: clamped to DEPTH.
- idx wraps only via clamping; it never exceeds DEPTH-1.
- Reset mid-run: all outputs return to reset values immediately (asynchronous).

Decomposition:
- Package lvs_pkg:
  - LVS_W
  - typedef lvs_word_t (logic [LVS_W-1:0])
  - FSM enum lvs_drv_state_e {IDLE, SEND, GAP, FIN}
- Sub-module lvs_entry_table: DEPTH x LVS_W register array with synchronous write, combinational read, and a write-enable gate driven by busy.

Test Plan:
1. Load table[0..2]=256'h1,256'h2,256'h3; num=3, gap=0, ready=1; start at cycle T → valid high T+1..T+3 with data 1,2,3; done at T+4; sent_cnt=3.
2. Same load, gap=2 → beats at T+1, T+4, T+7; valid low in between; done at T+8.
3. num=3, gap=0; ready low at T+2..T+4 → lvs_out holds 256'h2 while stalled; beats accepted at T+1, T+5, T+6; done at T+7.
4. num=0 start → no valid; done at T+1; busy never asserts.
5. num=4; abort at the cycle beat 1 would be accepted → valid low the next cycle, no done, sent_cnt=1; table write during the run is ignored, and a re-run replays the original data.
6. rst_n asserted mid-SEND → valid, busy and done go 0 immediately. After release, a start with num=2 sends table[0], table[1] normally.

Source files
------------

// File: rtl/lvs_pkg.sv
// Shared types for the LVS stimulus driver: entry width, entry word type, FSM states.
package lvs_pkg;

  localparam int unsigned LVS_W = 256;

  typedef logic [LVS_W-1:0] lvs_word_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    FIN
  } lvs_drv_state_e;

endpackage

// File: rtl/lvs_entry_table.sv
// DEPTH x LVS_W entry table: synchronous write (blocked while busy), combinational read.
module lvs_entry_table
  import lvs_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned LVS_W = lvs_pkg::LVS_W
) (
  input  logic                     clk,
  input  logic                     i_busy,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [LVS_W-1:0]         i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [LVS_W-1:0]         o_rd_data
);

  logic [LVS_W-1:0] r_mem [DEPTH];
  logic             w_wr;

  assign w_wr = i_wr_en & ~i_busy;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Forward a same-cycle write so a run started alongside it sees the new entry.
  assign o_rd_data = (w_wr && (i_wr_addr == i_rd_addr)) ? i_wr_data : r_mem[i_rd_addr];

endmodule

// File: rtl/lvs_stream_driver.sv
// Replays a programmable LVS entry table as a valid/ready stream with optional inter-beat gaps.
module lvs_stream_driver
  import lvs_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned LVS_W = lvs_pkg::LVS_W,
  parameter int unsigned GAP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [LVS_W-1:0]         wr_data,
  input  logic                     start,
  input  logic                     abort,
  input  logic [$clog2(DEPTH):0]   num_entries,
  input  logic [GAP_W-1:0]         gap_cycles,
  input  logic                     lvs_ready,
  output logic                     lvs_valid,
  output logic [LVS_W-1:0]         lvs_out,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   sent_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  lvs_drv_state_e   r_state;
  logic             r_valid;
  logic [LVS_W-1:0] r_out;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_sent;
  logic [CW-1:0]    r_num;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] r_gcnt;
  logic [AW-1:0]    r_idx;

  logic [AW-1:0]    w_rd_addr;
  logic [LVS_W-1:0] w_rd_data;
  logic [CW-1:0]    w_num_clamped;
  logic [CW-1:0]    w_sent_inc;

  lvs_entry_table #(
    .DEPTH (DEPTH),
    .LVS_W (LVS_W)
  ) u_table (
    .clk       (clk),
    .i_busy    (r_busy),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign w_num_clamped = (num_entries > CW'(DEPTH)) ? CW'(DEPTH) : num_entries;
  assign w_sent_inc    = r_sent + 1'b1;

  // SEND pre-fetches the entry after the one on the bus; GAP already advanced idx.
  always_comb begin
    w_rd_addr = '0;
    case (r_state)
      SEND:    w_rd_addr = r_idx + 1'b1;
      GAP:     w_rd_addr = r_idx;
      default: w_rd_addr = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sent  <= '0;
      r_num   <= '0;
      r_gap   <= '0;
      r_gcnt  <= '0;
      r_idx   <= '0;
    end else begin
      r_done <= 1'b0;
      if (abort && (r_state != IDLE)) begin
        r_state <= IDLE;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start && !abort) begin
              r_sent <= '0;
              if (num_entries == '0) begin
                r_state <= FIN;
                r_done  <= 1'b1;
              end else begin
                r_num   <= w_num_clamped;
                r_gap   <= gap_cycles;
                r_idx   <= '0;
                r_out   <= w_rd_data;
                r_valid <= 1'b1;
                r_busy  <= 1'b1;
                r_state <= SEND;
              end
            end
          end
          SEND: begin
            if (r_valid && lvs_ready) begin
              r_sent <= w_sent_inc;
              if (w_sent_inc == r_num) begin
                r_state <= FIN;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_idx <= r_idx + 1'b1;
                if (r_gap != '0) begin
                  r_state <= GAP;
                  r_valid <= 1'b0;
                  r_gcnt  <= r_gap;
                end else begin
                  r_out <= w_rd_data;
                end
              end
            end
          end
          GAP: begin
            if (r_gcnt == GAP_W'(1)) begin
              r_state <= SEND;
              r_valid <= 1'b1;
              r_out   <= w_rd_data;
            end else begin
              r_gcnt <= r_gcnt - 1'b1;
            end
          end
          FIN: begin
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign lvs_valid = r_valid;
  assign lvs_out   = r_out;
  assign busy      = r_busy;
  assign done      = r_done;
  assign sent_cnt  = r_sent;

endmodule

// File: tb/tb_lvs_stream_driver.sv
// Scoreboard bench for lvs_stream_driver: runs are scheduled by a cycle-level model, a monitor checks beats and done.
module tb_lvs_stream_driver;
  import lvs_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int CW    = 4;

  typedef struct {
    lvs_word_t data;
    int        cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  lvs_word_t       wr_data = '0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [CW-1:0]   num_entries = '0;
  logic [7:0]      gap_cycles = '0;
  logic            lvs_ready = 1'b1;
  logic            lvs_valid;
  lvs_word_t       lvs_out;
  logic            busy;
  logic            done;
  logic [CW-1:0]   sent_cnt;

  int        checks = 0;
  int        failures = 0;
  int        cyc = 0;
  lvs_word_t tbl [DEPTH];
  exp_t      eq [$];
  int        dq [$];

  lvs_stream_driver #(
    .DEPTH (DEPTH),
    .LVS_W (256),
    .GAP_W (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .abort       (abort),
    .num_entries (num_entries),
    .gap_cycles  (gap_cycles),
    .lvs_ready   (lvs_ready),
    .lvs_valid   (lvs_valid),
    .lvs_out     (lvs_out),
    .busy        (busy),
    .done        (done),
    .sent_cnt    (sent_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic lvs_word_t rnd_word();
    lvs_word_t w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Monitor: beat handshakes, done pulses and stall stability.
  bit        stalled = 1'b0;
  lvs_word_t held;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid_hold", lvs_valid, 1);
        check("stall_data_hold", lvs_out, held);
      end
      stalled = lvs_valid && !lvs_ready && !abort;
      held    = lvs_out;
      if (lvs_valid && lvs_ready && !abort) begin
        if (eq.size() == 0) begin
          check("unexpected_beat", lvs_out, 0);
          check("unexpected_beat_valid", lvs_valid, 0);
        end else begin
          exp_t e;
          e = eq.pop_front();
          check("beat_data", lvs_out, e.data);
          check("beat_cycle", cyc, e.cyc);
        end
      end
      if (done) begin
        if (dq.size() == 0) check("unexpected_done", done, 0);
        else check("done_cycle", cyc, dq.pop_front());
      end
    end
  end

  task automatic tbl_write(input int addr, input lvs_word_t data);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
    tbl[addr] = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // mode 0: always ready; 1: ~30% random stalls; 2: ready low at offsets 2..4
  task automatic run(input int num, input int gap, input int mode, input bit wr0,
                     input bit dup, input bit wrmid);
    int   n, t0, p, c, doff;
    bit   rp [512];
    exp_t e;
    n = (num > DEPTH) ? DEPTH : num;
    for (int k = 0; k < 512; k++) begin
      case (mode)
        1:       rp[k] = (k >= 200) || ($urandom_range(99) >= 30);
        2:       rp[k] = !(k >= 2 && k <= 4);
        default: rp[k] = 1'b1;
      endcase
    end
    @(posedge clk); #1;
    t0 = cyc;
    if (wr0) begin
      wr_en = 1'b1; wr_addr = '0; wr_data = rnd_word();
      tbl[0] = wr_data;
    end
    start = 1'b1; num_entries = CW'(num); gap_cycles = 8'(gap); lvs_ready = rp[0];
    c = 0;
    if (n == 0) begin
      doff = 1;
    end else begin
      p = 1;
      for (int i = 0; i < n; i++) begin
        c = p;
        while (!rp[c]) c++;
        e.data = tbl[i]; e.cyc = t0 + c;
        eq.push_back(e);
        p = c + 1 + gap;
      end
      doff = c + 1;
    end
    dq.push_back(t0 + doff);
    for (int k = 1; k <= doff + 1; k++) begin
      @(posedge clk); #1;
      start = 1'b0; wr_en = 1'b0; lvs_ready = rp[k];
      if (k == 1) check("busy_after_start", busy, (n > 0) ? 1 : 0);
      if (dup && n > 0 && k == 2) begin
        start = 1'b1; num_entries = CW'($urandom_range(1, 15));
      end
      if (wrmid && n > 0 && k < doff && $urandom_range(3) == 0) begin
        wr_en = 1'b1; wr_addr = AW'($urandom_range(DEPTH - 1)); wr_data = rnd_word();
      end
    end
    start = 1'b0; wr_en = 1'b0;
    check("beats_outstanding", eq.size(), 0);
    check("done_outstanding", dq.size(), 0);
    check("sent_cnt_end", sent_cnt, n);
    check("busy_end", busy, 0);
    eq.delete(); dq.delete();
  endtask

  initial begin
    int t0;
    exp_t e;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_valid", lvs_valid, 0);
    check("rst_out", lvs_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sent", sent_cnt, 0);

    for (int i = 0; i < DEPTH; i++) tbl_write(i, (i < 3) ? lvs_word_t'(i + 1) : rnd_word());

    run(3, 0, 0, 0, 0, 0);
    run(3, 2, 0, 0, 0, 0);
    run(3, 0, 2, 0, 0, 0);
    run(0, 0, 0, 0, 0, 0);

    // Abort as the second beat is presented; a write issued mid-run must not land.
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b1; num_entries = 4; gap_cycles = 0; lvs_ready = 1'b1;
    e.data = tbl[0]; e.cyc = t0 + 1; eq.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b1; wr_addr = '0; wr_data = rnd_word();
    @(posedge clk); #1;
    wr_en = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid", lvs_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_sent", sent_cnt, 1);
    repeat (3) @(posedge clk);
    check("abort_beats_outstanding", eq.size(), 0);
    eq.delete();
    run(4, 0, 0, 0, 0, 0);

    // abort and start together in IDLE: nothing starts
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; num_entries = 3;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 check("abort_start_valid", lvs_valid, 0);

    // Asynchronous reset in the middle of SEND
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b1; num_entries = 4; gap_cycles = 0; lvs_ready = 1'b1;
    e.data = tbl[0]; e.cyc = t0 + 1; eq.push_back(e);
    e.data = tbl[1]; e.cyc = t0 + 2; eq.push_back(e);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", lvs_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_out", lvs_out, 0);
    check("midrst_sent", sent_cnt, 0);
    check("midrst_beats_outstanding", eq.size(), 0);
    eq.delete(); dq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run(2, 0, 0, 0, 0, 0);

    run(12, 1, 1, 0, 0, 0);
    run(DEPTH, 0, 0, 1, 1, 1);

    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(2) == 0) tbl_write($urandom_range(DEPTH - 1), rnd_word());
      run($urandom_range(0, 12), $urandom_range(0, 3), $urandom_range(0, 1),
          ($urandom_range(3) == 0), ($urandom_range(2) == 0), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
